// File: rtl/rca_acc_pkg.sv
// Shared types and constants for the rca_accumulator stream summing block.
package rca_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

  localparam logic CIN_TIE = 1'b0;

endpackage

// File: rtl/rca_adder.sv
// Combinational W-bit ripple-carry adder built from a chain of full-adder cells.
module rca_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_carry;

  assign w_carry[0] = cin;

  // Each generate iteration is one full-adder cell; carry ripples bit 0 -> bit W-1.
  for (genvar i = 0; i < W; i++) begin : g_full_adder
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[W];

endmodule

// File: rtl/rca_accumulator.sv
// Sums N_SAMPLES valid/ready operands and presents the total plus a sticky overflow flag.
// Define RCA_ACC_SATURATE_EN to clamp the accumulator at all-ones on carry-out instead of wrapping.
module rca_accumulator
  import rca_acc_pkg::*;
#(
  parameter int W         = 4,
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  acc_state_t       r_state;
  acc_state_t       w_nextState;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic [W-1:0]     w_addSum;
  logic [W-1:0]     w_accNext;
  logic             w_cout;
  logic             w_beat;
  logic             w_lastBeat;
  logic             w_resultTaken;

  rca_adder #(.W(W)) u_adder (
    .a    (r_acc),
    .b    (in_data),
    .cin  (CIN_TIE),
    .sum  (w_addSum),
    .cout (w_cout)
  );

`ifdef RCA_ACC_SATURATE_EN
  assign w_accNext = w_cout ? {W{1'b1}} : w_addSum;
`else
  assign w_accNext = w_addSum;
`endif

  assign in_ready      = (r_state != HOLD);
  assign w_beat        = in_valid & in_ready;
  assign w_lastBeat    = w_beat & (r_cnt == LAST_CNT);
  assign w_resultTaken = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // clear overrides every transition, including a same-cycle result handshake.
  always_comb begin
    w_nextState = r_state;
    if (clear) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_beat) w_nextState = w_lastBeat ? HOLD : ACCUM;
        ACCUM:   if (w_lastBeat) w_nextState = HOLD;
        HOLD:    if (out_ready) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (clear || w_resultTaken) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_beat) begin
      r_acc <= w_accNext;
      r_cnt <= r_cnt + CNT_W'(1);
      r_ovf <= r_ovf | w_cout;
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_cnt;

endmodule

// File: tb/tb_rca_accumulator.sv
// Directed, scoreboard-driven bench for rca_accumulator (N_SAMPLES=4 and N_SAMPLES=1 instances).
module tb_rca_accumulator;

  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;

  logic         inValid;
  logic         inReady;
  logic [W-1:0] inData;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outSum;
  logic         outOvf;
  logic [2:0]   outCount;

  logic         inValid1;
  logic         inReady1;
  logic [W-1:0] inData1;
  logic         outValid1;
  logic         outReady1;
  logic [W-1:0] outSum1;
  logic         outOvf1;
  logic [0:0]   outCount1;

  typedef struct {
    int sum;
    int ovf;
    int count;
  } result_t;

  result_t scoreQ[$];
  int total = 0;
  int bad   = 0;
  int modelAcc;
  int modelOvf;
  int modelCnt;

  always #5 clk = ~clk;

  rca_accumulator #(.W(W), .N_SAMPLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_sum   (outSum),
    .out_ovf   (outOvf),
    .out_count (outCount)
  );

  rca_accumulator #(.W(W), .N_SAMPLES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (inValid1),
    .in_ready  (inReady1),
    .in_data   (inData1),
    .out_valid (outValid1),
    .out_ready (outReady1),
    .out_sum   (outSum1),
    .out_ovf   (outOvf1),
    .out_count (outCount1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelAcc = 0;
    modelOvf = 0;
    modelCnt = 0;
  endtask

  // Reference model of one accepted beat; pushes the expected frame result on the last beat.
  task automatic modelBeat(input int d);
    result_t r;
    int s;
    s = modelAcc + d;
    if (s >= (1 << W)) begin
      modelOvf = 1;
`ifdef RCA_ACC_SATURATE_EN
      modelAcc = (1 << W) - 1;
`else
      modelAcc = s - (1 << W);
`endif
    end else begin
      modelAcc = s;
    end
    modelCnt++;
    if (modelCnt == N) begin
      r.sum   = modelAcc;
      r.ovf   = modelOvf;
      r.count = N;
      scoreQ.push_back(r);
      modelReset();
    end
  endtask

  task automatic applyStimulus(input int d);
    int waitCycles;
    waitCycles = 0;
    inValid = 1'b1;
    inData  = W'(d);
    while (inReady !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (inReady !== 1'b1) begin
      checkOutput("beatTimeout", {31'd0, inReady}, 32'd1);
      inValid = 1'b0;
      return;
    end
    @(negedge clk);
    inValid = 1'b0;
    modelBeat(d);
  endtask

  task automatic waitResult(input string tag);
    int waitCycles;
    result_t exp;
    waitCycles = 0;
    while (outValid !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput({tag, "_valid"}, {31'd0, outValid}, 32'd1);
    checkOutput({tag, "_sbDepth"}, scoreQ.size(), 32'd1);
    if (scoreQ.size() == 0) return;
    exp = scoreQ.pop_front();
    checkOutput({tag, "_sum"}, {28'd0, outSum}, exp.sum);
    checkOutput({tag, "_ovf"}, {31'd0, outOvf}, exp.ovf);
    checkOutput({tag, "_count"}, {29'd0, outCount}, exp.count);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    inValid   = 1'b0;
    inData    = '0;
    outReady  = 1'b0;
    inValid1  = 1'b0;
    inData1   = '0;
    outReady1 = 1'b0;
    modelReset();

    #2;
    checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_sum", {28'd0, outSum}, 32'd0);
    checkOutput("rst_count", {29'd0, outCount}, 32'd0);
    checkOutput("rst_ovf", {31'd0, outOvf}, 32'd0);
    checkOutput("rst_inReady", {31'd0, inReady}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic frame 3,4,5,1");
    outReady = 1'b1;
    applyStimulus(3);
    applyStimulus(4);
    checkOutput("t1_count2", {29'd0, outCount}, 32'd2);
    applyStimulus(5);
    applyStimulus(1);
    checkOutput("t1_latency", {31'd0, outValid}, 32'd1);
    waitResult("t1");
    @(negedge clk);
    checkOutput("t1_released", {31'd0, outValid}, 32'd0);
    checkOutput("t1_cntClr", {29'd0, outCount}, 32'd0);

    $display("[TB] overflow frame 13,14,0,0");
    applyStimulus(13);
    applyStimulus(14);
    applyStimulus(0);
    applyStimulus(0);
    waitResult("t2");
    @(negedge clk);

    $display("[TB] backpressure");
    outReady = 1'b0;
    repeat (4) applyStimulus(1);
    inValid = 1'b1;
    inData  = 4'd2;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_inReady", {31'd0, inReady}, 32'd0);
      checkOutput("t3_sum", {28'd0, outSum}, 32'd4);
      checkOutput("t3_validHeld", {31'd0, outValid}, 32'd1);
      @(negedge clk);
    end
    waitResult("t3");
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("t3_idle", {31'd0, outValid}, 32'd0);
    checkOutput("t3_noEarlyBeat", {29'd0, outCount}, 32'd0);
    repeat (4) applyStimulus(2);
    waitResult("t3b");
    @(negedge clk);

    $display("[TB] clear mid-frame");
    applyStimulus(7);
    applyStimulus(7);
    clear   = 1'b1;
    inValid = 1'b1;
    inData  = 4'd7;
    @(negedge clk);
    clear   = 1'b0;
    inValid = 1'b0;
    modelReset();
    checkOutput("t4_cntClr", {29'd0, outCount}, 32'd0);
    checkOutput("t4_sumClr", {28'd0, outSum}, 32'd0);
    repeat (4) applyStimulus(1);
    waitResult("t4");
    @(negedge clk);

    $display("[TB] async reset in HOLD");
    outReady = 1'b0;
    repeat (4) applyStimulus(2);
    waitResult("t5");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_validAsync", {31'd0, outValid}, 32'd0);
    checkOutput("t5_sumAsync", {28'd0, outSum}, 32'd0);
    checkOutput("t5_countAsync", {29'd0, outCount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t5_idleReady", {31'd0, inReady}, 32'd1);
    checkOutput("t5_idleValid", {31'd0, outValid}, 32'd0);
    outReady = 1'b1;

    $display("[TB] single-sample frames 9 then 6");
    outReady1 = 1'b1;
    inValid1  = 1'b1;
    inData1   = 4'd9;
    checkOutput("t6_ready", {31'd0, inReady1}, 32'd1);
    @(negedge clk);
    inData1 = 4'd6;
    checkOutput("t6_valid9", {31'd0, outValid1}, 32'd1);
    checkOutput("t6_sum9", {28'd0, outSum1}, 32'd9);
    checkOutput("t6_count9", {31'd0, outCount1}, 32'd1);
    checkOutput("t6_holdReady", {31'd0, inReady1}, 32'd0);
    @(negedge clk);
    checkOutput("t6_gap", {31'd0, outValid1}, 32'd0);
    @(negedge clk);
    inValid1 = 1'b0;
    checkOutput("t6_valid6", {31'd0, outValid1}, 32'd1);
    checkOutput("t6_sum6", {28'd0, outSum1}, 32'd6);
    @(negedge clk);
    checkOutput("t6_done", {31'd0, outValid1}, 32'd0);

    checkOutput("sb_empty", scoreQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
